// File: rtl/edge_mask_packer.sv
// Packs a 1-bit-per-pixel edge stream into 32-bit mask words with frame/line markers
// and buffers them in a show-ahead FIFO feeding a valid/ready stream.
module edge_mask_packer #(
  parameter logic [10:0] IMG_HDISP  = 11'd1280,
  parameter logic [10:0] IMG_VDISP  = 11'd720,
  parameter int unsigned FIFO_DEPTH = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        EN,
  input  logic        in_vs,
  input  logic        in_de,
  input  logic        in_bit,
  output logic [31:0] m_data,
  output logic        m_valid,
  input  logic        m_ready,
  output logic        m_sof,
  output logic        m_eol,
  output logic        m_eof,
  output logic        overflow,
  output logic        frame_err
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);

  logic        r_vs_d;
  logic        r_de_d;
  logic [10:0] r_x;
  logic [10:0] r_y;
  logic [4:0]  r_bit_idx;
  logic [31:0] r_shift;
  logic        r_sof_pend;
  logic        r_push_vld;
  logic [34:0] r_push_word;
  logic        r_overflow;
  logic        r_frame_err;
  logic [34:0] r_mem [FIFO_DEPTH];
  logic [AW:0] r_wr_ptr;
  logic [AW:0] r_rd_ptr;

  logic        w_fs;
  logic        w_pix;
  logic        w_line_end;
  logic        w_in_frame;
  logic        w_last_line;
  logic        w_eol_full;
  logic [31:0] w_word;
  logic        w_empty;
  logic        w_full;
  logic        w_pop;
  logic        w_wr;
  logic        w_drop;
  logic [34:0] w_head;

  // de_d tracks the effective (EN-qualified) enable, so dropping EN mid-line ends the line too
  assign w_fs        = in_vs & ~r_vs_d;
  assign w_pix       = EN & in_de;
  assign w_line_end  = r_de_d & ~w_pix;
  assign w_in_frame  = (r_y < IMG_VDISP);
  assign w_last_line = (r_y == (IMG_VDISP - 11'd1));
  assign w_eol_full  = ((r_x + 11'd1) == IMG_HDISP);
  assign w_word      = r_shift | ({31'd0, in_bit} << r_bit_idx);

  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_pop   = ~w_empty & m_ready;
  assign w_wr    = r_push_vld & (~w_full | w_pop);
  assign w_drop  = r_push_vld & w_full & ~w_pop;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_vs_d      <= 1'b0;
      r_de_d      <= 1'b0;
      r_x         <= '0;
      r_y         <= '0;
      r_bit_idx   <= '0;
      r_shift     <= '0;
      r_sof_pend  <= 1'b0;
      r_push_vld  <= 1'b0;
      r_push_word <= '0;
      r_overflow  <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_vs_d     <= in_vs;
      r_de_d     <= w_pix;
      r_push_vld <= 1'b0;
      if (w_fs) begin
        // A frame start mid-line abandons the partial word and charges the error to the new frame
        r_x         <= '0;
        r_y         <= '0;
        r_bit_idx   <= '0;
        r_shift     <= '0;
        r_sof_pend  <= 1'b1;
        r_de_d      <= 1'b0;
        r_frame_err <= r_de_d | w_pix;
      end else if (w_pix) begin
        if (w_in_frame) begin
          r_x       <= r_x + 11'd1;
          r_bit_idx <= r_bit_idx + 5'd1;
          if (r_bit_idx == 5'd31) begin
            r_push_vld  <= 1'b1;
            r_push_word <= {w_last_line & w_eol_full, w_eol_full, r_sof_pend, w_word};
            r_sof_pend  <= 1'b0;
            r_shift     <= '0;
          end else begin
            r_shift <= w_word;
          end
        end else begin
          r_frame_err <= 1'b1;
        end
      end else if (w_line_end) begin
        if (w_in_frame) begin
          if (r_bit_idx != 5'd0) begin
            r_push_vld  <= 1'b1;
            r_push_word <= {w_last_line, 1'b1, r_sof_pend, r_shift};
            r_sof_pend  <= 1'b0;
          end
          if (r_x != IMG_HDISP) r_frame_err <= 1'b1;
          r_y <= r_y + 11'd1;
        end
        r_x       <= '0;
        r_bit_idx <= '0;
        r_shift   <= '0;
      end
      if (w_fs)   r_overflow <= 1'b0;
      if (w_drop) r_overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wr_ptr[AW-1:0]] <= r_push_word;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_wr)  r_wr_ptr <= r_wr_ptr + {{AW{1'b0}}, 1'b1};
      if (w_pop) r_rd_ptr <= r_rd_ptr + {{AW{1'b0}}, 1'b1};
    end
  end

  assign w_head    = r_mem[r_rd_ptr[AW-1:0]];
  assign m_valid   = ~w_empty;
  assign m_data    = w_empty ? '0 : w_head[31:0];
  assign m_sof     = ~w_empty & w_head[32];
  assign m_eol     = ~w_empty & w_head[33];
  assign m_eof     = ~w_empty & w_head[34];
  assign overflow  = r_overflow;
  assign frame_err = r_frame_err;

endmodule

// File: tb/tb_edge_mask_packer.sv
// Directed bench for edge_mask_packer on a scaled-down 64x8 frame with an 8-entry FIFO;
// a line-level model predicts the words, a monitor collects pops and checks stall stability.
module tb_edge_mask_packer;

  localparam int HD    = 64;
  localparam int VD    = 8;
  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        EN = 1'b1;
  logic        in_vs = 1'b0;
  logic        in_de = 1'b0;
  logic        in_bit = 1'b0;
  logic        m_ready = 1'b1;
  logic [31:0] m_data;
  logic        m_valid, m_sof, m_eol, m_eof, overflow, frame_err;

  int          total = 0;
  int          bad = 0;
  logic [34:0] exp_q[$];
  logic [34:0] got_q[$];
  logic        sof_pend_m = 1'b0;
  logic        bp = 1'b0;
  logic        prev_stall = 1'b0;
  logic [34:0] prev_word = '0;
  logic [34:0] cur_word;
  logic [34:0] g0, g1;

  edge_mask_packer #(
    .IMG_HDISP (11'(HD)),
    .IMG_VDISP (11'(VD)),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .EN       (EN),
    .in_vs    (in_vs),
    .in_de    (in_de),
    .in_bit   (in_bit),
    .m_data   (m_data),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .m_sof    (m_sof),
    .m_eol    (m_eol),
    .m_eof    (m_eof),
    .overflow (overflow),
    .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic pix(input int pat, input int yl, input int i);
    int h;
    h = i * 13 + yl * 7 + 3;
    case (pat)
      0:       return i[0];
      1:       return 1'b1;
      default: return h[3] ^ h[1];
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
    if (bp) m_ready = ~m_ready;
  endtask

  task automatic idle(input int n);
    in_de = 1'b0;
    repeat (n) step();
  endtask

  task automatic frame_start();
    in_vs = 1'b1;
    step();
    in_vs = 1'b0;
    step();
    sof_pend_m = 1'b1;
  endtask

  task automatic model_line(input int len, input int pat, input int yl);
    int nw;
    logic [31:0] d;
    logic eol, eof;
    if (yl >= VD) return;
    nw = (len + 31) / 32;
    for (int w = 0; w < nw; w++) begin
      d = '0;
      for (int b = 0; b < 32; b++)
        if (w * 32 + b < len) d[b] = pix(pat, yl, w * 32 + b);
      eol = (w * 32 + 32 == HD) || ((w == nw - 1) && (len % 32 != 0));
      eof = eol && (yl == VD - 1);
      exp_q.push_back({eof, eol, sof_pend_m, d});
      sof_pend_m = 1'b0;
    end
  endtask

  task automatic drive_line(input int len, input int pat, input int yl);
    for (int i = 0; i < len; i++) begin
      in_de  = 1'b1;
      in_bit = pix(pat, yl, i);
      step();
    end
    in_de  = 1'b0;
    in_bit = 1'b0;
    model_line(len, pat, yl);
    idle(4);
  endtask

  task automatic drain();
    int quiet;
    int n;
    quiet = 0;
    n = 0;
    if (!bp) m_ready = 1'b1;
    while (quiet < 4 && n < 500) begin
      step();
      n++;
      if (!m_valid) quiet++;
      else quiet = 0;
    end
    if (quiet < 4) chk("drain_timeout", quiet, 4);
  endtask

  task automatic compare_q(input string tag);
    int n;
    chk({tag, "_cnt"}, got_q.size(), exp_q.size());
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) chk($sformatf("%s_w%0d", tag, i), got_q[i], exp_q[i]);
    got_q.delete();
    exp_q.delete();
  endtask

  always @(negedge clk) begin
    cur_word = {m_eof, m_eol, m_sof, m_data};
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) chk("stall_hold", {m_valid, cur_word}, {1'b1, prev_word});
      if (m_valid && m_ready) got_q.push_back(cur_word);
      prev_stall = m_valid & ~m_ready;
      prev_word  = cur_word;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    repeat (3) step();
    chk("rst_valid", m_valid, 0);
    chk("rst_data", m_data, 0);
    chk("rst_flags", {m_sof, m_eol, m_eof}, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_ferr", frame_err, 0);
    rst = 1'b0;
    step();

    // full frame of alternating bits
    frame_start();
    for (int y = 0; y < VD; y++) drive_line(HD, 0, y);
    drain();
    g0 = (got_q.size() > 0) ? got_q[0] : '0;
    g1 = (got_q.size() > 0) ? got_q[got_q.size() - 1] : '0;
    chk("t1_first", g0, {3'b001, 32'hAAAAAAAA});
    chk("t1_last", g1, {3'b110, 32'hAAAAAAAA});
    compare_q("t1");
    chk("t1_ferr", frame_err, 0);
    chk("t1_ovf", overflow, 0);

    // a line past the last expected line is discarded and flagged
    drive_line(HD, 0, VD);
    drain();
    compare_q("xline");
    chk("xline_ferr", frame_err, 1);

    // short line: padding, forced eol, frame_err, cleared by next frame start
    frame_start();
    chk("t5_ferr_clr", frame_err, 0);
    drive_line(40, 1, 0);
    drain();
    g0 = (got_q.size() > 0) ? got_q[0] : '0;
    g1 = (got_q.size() > 1) ? got_q[1] : '0;
    chk("t2_w0", g0, {3'b001, 32'hFFFFFFFF});
    chk("t2_w1", g1, {3'b010, 32'h000000FF});
    compare_q("t2");
    chk("t5_ferr", frame_err, 1);
    frame_start();
    chk("t5_ferr_next", frame_err, 0);

    // stalled frame overflows the FIFO; the oldest words survive
    m_ready = 1'b0;
    frame_start();
    for (int y = 0; y < VD; y++) drive_line(HD, 2, y);
    idle(5);
    chk("t3_ovf", overflow, 1);
    chk("t3_valid", m_valid, 1);
    chk("t3_head", {m_eof, m_eol, m_sof, m_data}, exp_q[0]);
    while (exp_q.size() > DEPTH) void'(exp_q.pop_back());
    drain();
    compare_q("t3");

    // backpressure toggling every cycle
    frame_start();
    chk("t4_ovf_clr", overflow, 0);
    bp = 1'b1;
    m_ready = 1'b1;
    drive_line(HD, 2, 0);
    drive_line(HD, 2, 1);
    drain();
    bp = 1'b0;
    m_ready = 1'b1;
    compare_q("t4");

    // reset mid-line with 5 words queued
    m_ready = 1'b0;
    frame_start();
    drive_line(HD, 2, 0);
    drive_line(HD, 2, 1);
    for (int i = 0; i < 40; i++) begin
      in_de  = 1'b1;
      in_bit = pix(2, 2, i);
      step();
    end
    chk("t6_queued", m_valid, 1);
    rst = 1'b1;
    step();
    chk("t6_valid", m_valid, 0);
    chk("t6_data", m_data, 0);
    chk("t6_flags", {m_sof, m_eol, m_eof, overflow, frame_err}, 0);
    in_de = 1'b0;
    rst = 1'b0;
    step();
    exp_q.delete();
    got_q.delete();
    sof_pend_m = 1'b0;
    m_ready = 1'b1;
    frame_start();
    drive_line(HD, 0, 0);
    drain();
    g0 = (got_q.size() > 0) ? got_q[0] : '0;
    chk("t6_sof", g0[32], 1);
    compare_q("t6");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
